fabric_boot_sequencer: RTL and testbench
========================================

// Module: fabric_boot_sequencer
// PURPOSE
//  Sequences fabric configuration between the SPI controller (flash boot), the SPI receiver (host push) and fabric_config.
//  Issues startup and warmboot loads, gates the bitstream word stream, enforces a per-word watchdog and retries.
//  Falls back to slot 0 when a warmboot slot fails. Sits between the SPI front-ends, fabric_config and the fabric WARMBOOT port.
// PARAMETERS
//  SLOT_WIDTH      4       width of slot number (16 slots)
//  TIMEOUT_CYCLES  65536   max cycles between start/words in LOAD before a load is declared failed
//  MAX_RETRIES     2       extra attempts per slot before fallback/error
//  HOLDOFF_CYCLES  16      cycles warmboot_reset_o is held before a warmboot load starts
// PORTS
//  clk_i              in   1   clock
//  rst_ni             in   1   reset, asynchronous active-low
//  mode_i             in   1   0=SPI controller boot, 1=SPI receiver; already synchronised
//  warmboot_boot_i    in   1   warmboot request from fabric (level)
//  warmboot_slot_i    in   SW  requested slot
//  ctrl_start_o       out  1   one-cycle start pulse to SPI controller
//  ctrl_slot_o        out  SW  slot to read; held stable from start to end of load
//  ctrl_busy_i        in   1   SPI controller reading
//  ctrl_data_i        in   32  controller bitstream word
//  ctrl_valid_i       in   1   controller word strobe
//  rcv_data_i         in   32  receiver bitstream word
//  rcv_valid_i        in   1   receiver word strobe
//  cfg_data_o         out  32  word to fabric_config
//  cfg_valid_o        out  1   word strobe to fabric_config
//  cfg_busy_i         in   1   fabric_config busy
//  cfg_configured_i   in   1   fabric configured
//  warmboot_reset_o   out  1   reset to fabric WARMBOOT logic
//  busy_o             out  1   a load is in progress (START..LOAD, HOLDOFF)
//  error_o            out  1   sticky boot failure
//  active_slot_o      out  SW  slot of the last started load
// BEHAVIOUR
//  Reset: all outputs 0; state RESET; retry count 0; watchdog 0.
//  States: RESET, START, LOAD, CHECK, DONE, HOLDOFF, RCV, ERROR.
//  RESET (first cycle out of reset): mode_i=0 -> START with slot 0; mode_i=1 -> RCV.
//  START: ctrl_start_o=1 for exactly one cycle, ctrl_slot_o/active_slot_o=slot; watchdog cleared; -> LOAD.
//  LOAD: ctrl words forwarded: cfg_data_o/cfg_valid_o registered, 1-cycle latency, no drops, no duplicates.
//   Watchdog increments each cycle, clears on ctrl_valid_i. At TIMEOUT_CYCLES -> CHECK (failed).
//   ctrl_busy_i=0 && cfg_busy_i=0, at least 2 cycles after START -> CHECK.
//  CHECK (1 cycle): cfg_configured_i=1 and no timeout -> DONE, retries cleared.
//   Else, retries<MAX_RETRIES: retries++, -> START with the same slot.
//   Else, slot!=0: slot=0, retries=0, -> START.
//   Else: -> ERROR.
//  DONE: rising edge of warmboot_boot_i (registered previous value) while mode_i=0 -> latch warmboot_slot_i, -> HOLDOFF.
//   mode_i=1 in DONE -> RCV. A level held high never re-triggers.
//  HOLDOFF: warmboot_reset_o=1 for HOLDOFF_CYCLES cycles -> START. Requests are ignored during HOLDOFF and loads.
//  RCV: receiver words forwarded, same 1-cycle registered path; controller words and warmboot are ignored.
//   mode_i=0 while cfg_busy_i=0 -> START slot 0.
//  ERROR: error_o=1 (sticky until reset); no forwarding. A warmboot rising edge -> HOLDOFF with the requested slot;
//   error_o stays 1. mode_i=1 -> RCV.
//  warmboot_reset_o is also 1 whenever cfg_busy_i=1.
//  Words from the non-selected source are dropped, never queued.
//  Async reset mid-load: all outputs 0 immediately, no residual cfg_valid_o.
// TESTING
//  Startup, mode_i=0: ctrl_start_o pulse with slot 0; 3 words -> cfg_valid_o 3 pulses with matching data, +1 cycle each.
//   busy/configured drop -> DONE, error_o=0.
//  Warmboot: warmboot_slot_i=5 with a rising edge in DONE -> warmboot_reset_o high 16 cycles, then ctrl_start_o with slot 5.
//   A request held high does not repeat.
//  Timeout: no ctrl_valid_i for 65536 cycles on slot 5 -> 3 starts on slot 5, then start slot 0.
//   Slot 0 fails 3x -> error_o=1.
//  Receiver: mode_i=1 from reset -> no ctrl_start_o; rcv words forwarded; ctrl_valid_i words are not forwarded.
//  Reset asserted mid-LOAD after 10 words -> outputs 0 same cycle; release -> fresh start on slot 0.
//  Checker: cfg_valid_o count equals forwarded-source valid count in every load.

Source files
------------

// File: rtl/fabric_boot_sequencer.sv
// Boot sequencer between the SPI front-ends and fabric_config: startup/warmboot loads,
// bitstream word gating, per-word watchdog, retries and fallback to slot 0.
module fabric_boot_sequencer #(
  parameter int SLOT_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 2,
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  mode_i,
  input  logic                  warmboot_boot_i,
  input  logic [SLOT_WIDTH-1:0] warmboot_slot_i,
  output logic                  ctrl_start_o,
  output logic [SLOT_WIDTH-1:0] ctrl_slot_o,
  input  logic                  ctrl_busy_i,
  input  logic [31:0]           ctrl_data_i,
  input  logic                  ctrl_valid_i,
  input  logic [31:0]           rcv_data_i,
  input  logic                  rcv_valid_i,
  output logic [31:0]           cfg_data_o,
  output logic                  cfg_valid_o,
  input  logic                  cfg_busy_i,
  input  logic                  cfg_configured_i,
  output logic                  warmboot_reset_o,
  output logic                  busy_o,
  output logic                  error_o,
  output logic [SLOT_WIDTH-1:0] active_slot_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HO_W = $clog2(HOLDOFF_CYCLES + 1);
  localparam int RT_W = $clog2(MAX_RETRIES + 2);

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_START   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CHECK   = 3'd3,
    ST_DONE    = 3'd4,
    ST_HOLDOFF = 3'd5,
    ST_RCV     = 3'd6,
    ST_ERROR   = 3'd7
  } state_e;

  state_e                state_q, state_d;
  logic [SLOT_WIDTH-1:0] slot_q, slot_d;
  logic [RT_W-1:0]       retries_q, retries_d;
  logic [WD_W-1:0]       wdog_q, wdog_d;
  logic [HO_W-1:0]       holdoff_q, holdoff_d;
  logic                  seen_q, seen_d;
  logic                  timeout_q, timeout_d;
  logic                  wb_prev_q, wb_prev_d;
  logic [31:0]           cfg_data_q, cfg_data_d;
  logic                  cfg_valid_q, cfg_valid_d;
  logic                  ctrl_start_q, ctrl_start_d;
  logic                  warmboot_reset_q, warmboot_reset_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;
  logic [SLOT_WIDTH-1:0] active_slot_q, active_slot_d;
  logic                  wb_rise_s;

  assign wb_rise_s = warmboot_boot_i & ~wb_prev_q;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    retries_d = retries_q;
    wdog_d    = wdog_q;
    holdoff_d = holdoff_q;
    seen_d    = seen_q;
    timeout_d = timeout_q;
    wb_prev_d = warmboot_boot_i;

    case (state_q)
      ST_RESET: begin
        if (mode_i) begin
          state_d = ST_RCV;
        end else begin
          state_d   = ST_START;
          slot_d    = '0;
          retries_d = '0;
        end
      end
      ST_START: begin
        wdog_d    = '0;
        seen_d    = 1'b0;
        timeout_d = 1'b0;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        // seen_q guarantees the done condition is only honoured 2+ cycles after START
        seen_d = 1'b1;
        if (ctrl_valid_i) begin
          wdog_d = '0;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
        end
        if (!ctrl_valid_i && (wdog_q == WD_W'(TIMEOUT_CYCLES - 1))) begin
          timeout_d = 1'b1;
          state_d   = ST_CHECK;
        end else if (seen_q && !ctrl_busy_i && !cfg_busy_i) begin
          state_d = ST_CHECK;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_CHECK: begin
        if (cfg_configured_i && !timeout_q) begin
          retries_d = '0;
          state_d   = ST_DONE;
        end else if (retries_q < RT_W'(MAX_RETRIES)) begin
          retries_d = retries_q + RT_W'(1);
          state_d   = ST_START;
        end else if (slot_q != '0) begin
          slot_d    = '0;
          retries_d = '0;
          state_d   = ST_START;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_DONE, ST_ERROR: begin
        if (mode_i) begin
          state_d = ST_RCV;
        end else if (wb_rise_s) begin
          slot_d    = warmboot_slot_i;
          retries_d = '0;
          holdoff_d = '0;
          state_d   = ST_HOLDOFF;
        end else begin
          state_d = state_q;
        end
      end
      ST_HOLDOFF: begin
        if (holdoff_q == HO_W'(HOLDOFF_CYCLES - 1)) begin
          state_d = ST_START;
        end else begin
          holdoff_d = holdoff_q + HO_W'(1);
        end
      end
      ST_RCV: begin
        if (!mode_i && !cfg_busy_i) begin
          slot_d    = '0;
          retries_d = '0;
          state_d   = ST_START;
        end else begin
          state_d = ST_RCV;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase

    // Only the source owning the current state reaches fabric_config; the other is dropped
    cfg_valid_d = 1'b0;
    cfg_data_d  = cfg_data_q;
    if ((state_q == ST_LOAD) && ctrl_valid_i) begin
      cfg_valid_d = 1'b1;
      cfg_data_d  = ctrl_data_i;
    end else if ((state_q == ST_RCV) && rcv_valid_i) begin
      cfg_valid_d = 1'b1;
      cfg_data_d  = rcv_data_i;
    end else begin
      cfg_valid_d = 1'b0;
    end

    ctrl_start_d     = (state_d == ST_START);
    active_slot_d    = (state_d == ST_START) ? slot_d : active_slot_q;
    busy_d           = (state_d == ST_START) || (state_d == ST_LOAD) ||
                       (state_d == ST_CHECK) || (state_d == ST_HOLDOFF);
    warmboot_reset_d = (state_d == ST_HOLDOFF) || cfg_busy_i;
    error_d          = error_q || (state_d == ST_ERROR);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= ST_RESET;
      slot_q           <= '0;
      retries_q        <= '0;
      wdog_q           <= '0;
      holdoff_q        <= '0;
      seen_q           <= 1'b0;
      timeout_q        <= 1'b0;
      wb_prev_q        <= 1'b0;
      cfg_data_q       <= '0;
      cfg_valid_q      <= 1'b0;
      ctrl_start_q     <= 1'b0;
      warmboot_reset_q <= 1'b0;
      busy_q           <= 1'b0;
      error_q          <= 1'b0;
      active_slot_q    <= '0;
    end else begin
      state_q          <= state_d;
      slot_q           <= slot_d;
      retries_q        <= retries_d;
      wdog_q           <= wdog_d;
      holdoff_q        <= holdoff_d;
      seen_q           <= seen_d;
      timeout_q        <= timeout_d;
      wb_prev_q        <= wb_prev_d;
      cfg_data_q       <= cfg_data_d;
      cfg_valid_q      <= cfg_valid_d;
      ctrl_start_q     <= ctrl_start_d;
      warmboot_reset_q <= warmboot_reset_d;
      busy_q           <= busy_d;
      error_q          <= error_d;
      active_slot_q    <= active_slot_d;
    end
  end

  assign ctrl_start_o     = ctrl_start_q;
  assign ctrl_slot_o      = active_slot_q;
  assign active_slot_o    = active_slot_q;
  assign cfg_data_o       = cfg_data_q;
  assign cfg_valid_o      = cfg_valid_q;
  assign warmboot_reset_o = warmboot_reset_q;
  assign busy_o           = busy_q;
  assign error_o          = error_q;

endmodule

// File: tb/tb_fabric_boot_sequencer.sv
// Directed bench for fabric_boot_sequencer: startup, warmboot, timeout/fallback/error,
// mid-load reset and receiver mode. Watchdog shortened so the run stays short.
module tb_fabric_boot_sequencer;
  localparam int SW = 4;
  localparam int TO = 64;
  localparam int HO = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          mode_i;
  logic          warmboot_boot_i;
  logic [SW-1:0] warmboot_slot_i;
  logic          ctrl_start_o;
  logic [SW-1:0] ctrl_slot_o;
  logic          ctrl_busy_i;
  logic [31:0]   ctrl_data_i;
  logic          ctrl_valid_i;
  logic [31:0]   rcv_data_i;
  logic          rcv_valid_i;
  logic [31:0]   cfg_data_o;
  logic          cfg_valid_o;
  logic          cfg_busy_i;
  logic          cfg_configured_i;
  logic          warmboot_reset_o;
  logic          busy_o;
  logic          error_o;
  logic [SW-1:0] active_slot_o;

  fabric_boot_sequencer #(
    .SLOT_WIDTH(SW), .TIMEOUT_CYCLES(TO), .MAX_RETRIES(2), .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .mode_i(mode_i),
    .warmboot_boot_i(warmboot_boot_i), .warmboot_slot_i(warmboot_slot_i),
    .ctrl_start_o(ctrl_start_o), .ctrl_slot_o(ctrl_slot_o), .ctrl_busy_i(ctrl_busy_i),
    .ctrl_data_i(ctrl_data_i), .ctrl_valid_i(ctrl_valid_i),
    .rcv_data_i(rcv_data_i), .rcv_valid_i(rcv_valid_i),
    .cfg_data_o(cfg_data_o), .cfg_valid_o(cfg_valid_o), .cfg_busy_i(cfg_busy_i),
    .cfg_configured_i(cfg_configured_i), .warmboot_reset_o(warmboot_reset_o),
    .busy_o(busy_o), .error_o(error_o), .active_slot_o(active_slot_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc       = 0;
  int start_cnt = 0;
  int vld_cnt   = 0;
  int start_slots[$];
  int start_cycs[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor of start pulses and forwarded words
  always @(negedge clk) begin
    if (ctrl_start_o === 1'b1) begin
      start_cnt <= start_cnt + 1;
      start_slots.push_back(int'(ctrl_slot_o));
      start_cycs.push_back(cyc);
    end
    if (cfg_valid_o === 1'b1) vld_cnt <= vld_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one word from a source for one cycle and check the registered forward
  task automatic send_word(input bit from_rcv, input logic [31:0] d, input bit exp_fwd);
    if (from_rcv) begin
      rcv_data_i = d; rcv_valid_i = 1'b1;
    end else begin
      ctrl_data_i = d; ctrl_valid_i = 1'b1;
    end
    tick(1);
    chk("fwd_valid", {31'd0, cfg_valid_o}, {31'd0, exp_fwd});
    if (exp_fwd) chk("fwd_data", cfg_data_o, d);
    rcv_valid_i  = 1'b0;
    ctrl_valid_i = 1'b0;
  endtask

  // Count warmboot_reset_o high cycles (bounded), leaving the bench at the first low cycle
  task automatic count_holdoff(output int hi);
    hi = 0;
    while ((warmboot_reset_o === 1'b1) && (hi < 100)) begin
      hi++;
      tick(1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, v0, hi, exp_slots[6];
    bit seen_err;
    exp_slots = '{5, 5, 5, 0, 0, 0};

    rst_ni = 1'b0; mode_i = 1'b0; warmboot_boot_i = 1'b0; warmboot_slot_i = '0;
    ctrl_busy_i = 1'b0; ctrl_data_i = '0; ctrl_valid_i = 1'b0;
    rcv_data_i = '0; rcv_valid_i = 1'b0; cfg_busy_i = 1'b0; cfg_configured_i = 1'b0;
    tick(3);
    chk("rst_cfg_valid", {31'd0, cfg_valid_o}, 32'd0);
    chk("rst_start", {31'd0, ctrl_start_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_error", {31'd0, error_o}, 32'd0);
    chk("rst_wbreset", {31'd0, warmboot_reset_o}, 32'd0);
    chk("rst_slot", {28'd0, active_slot_o}, 32'd0);

    // Startup from flash, slot 0
    rst_ni = 1'b1;
    tick(1);
    chk("boot_start", {31'd0, ctrl_start_o}, 32'd1);
    chk("boot_slot", {28'd0, ctrl_slot_o}, 32'd0);
    chk("boot_busy", {31'd0, busy_o}, 32'd1);
    ctrl_busy_i = 1'b1;
    tick(1);
    chk("start_one_cycle", {31'd0, ctrl_start_o}, 32'd0);
    v0 = vld_cnt;
    send_word(1'b0, 32'hA5A5_0001, 1'b1);
    send_word(1'b0, 32'h5A5A_0002, 1'b1);
    send_word(1'b0, 32'hDEAD_BEEF, 1'b1);
    ctrl_busy_i = 1'b0; cfg_configured_i = 1'b1;
    tick(4);
    chk("boot_done_busy", {31'd0, busy_o}, 32'd0);
    chk("boot_done_error", {31'd0, error_o}, 32'd0);
    chk("boot_start_cnt", start_cnt, 32'd1);
    chk("boot_word_cnt", vld_cnt - v0, 32'd3);
    send_word(1'b0, 32'h1234_5678, 1'b0);

    // Warmboot to slot 5
    warmboot_slot_i = 4'd5; warmboot_boot_i = 1'b1;
    tick(1);
    chk("wb_busy", {31'd0, busy_o}, 32'd1);
    count_holdoff(hi);
    chk("wb_holdoff_len", hi, HO);
    chk("wb_start", {31'd0, ctrl_start_o}, 32'd1);
    chk("wb_slot", {28'd0, ctrl_slot_o}, 32'd5);
    chk("wb_active", {28'd0, active_slot_o}, 32'd5);
    ctrl_busy_i = 1'b1;
    tick(1);
    send_word(1'b0, 32'h0000_0055, 1'b1);
    send_word(1'b0, 32'h0000_00AA, 1'b1);
    ctrl_busy_i = 1'b0;
    tick(4);
    chk("wb_done_busy", {31'd0, busy_o}, 32'd0);
    s0 = start_cnt;
    tick(30);
    chk("wb_no_retrigger", start_cnt, s0);
    chk("wb_reset_low", {31'd0, warmboot_reset_o}, 32'd0);

    // Timeouts: 3 attempts on slot 5, 3 on slot 0, then error
    cfg_configured_i = 1'b0; ctrl_busy_i = 1'b1; warmboot_boot_i = 1'b0;
    tick(2);
    s0 = start_slots.size();
    warmboot_slot_i = 4'd5; warmboot_boot_i = 1'b1;
    seen_err = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (error_o === 1'b1) begin
        seen_err = 1'b1;
        break;
      end
      tick(1);
    end
    chk("to_error_set", {31'd0, seen_err}, 32'd1);
    tick(2);
    chk("to_start_count", start_slots.size() - s0, 32'd6);
    if (start_slots.size() - s0 == 6) begin
      for (int i = 0; i < 6; i++) chk("to_start_slot", start_slots[s0 + i], exp_slots[i]);
      chk("to_retry_gap", start_cycs[s0 + 1] - start_cycs[s0], TO + 2);
    end
    chk("to_err_busy", {31'd0, busy_o}, 32'd0);

    // Warmboot out of ERROR keeps error_o
    warmboot_boot_i = 1'b0;
    tick(2);
    warmboot_slot_i = 4'd3; warmboot_boot_i = 1'b1;
    tick(1);
    chk("err_wb_sticky", {31'd0, error_o}, 32'd1);
    count_holdoff(hi);
    chk("err_wb_holdoff", hi, HO);
    chk("err_wb_slot", {28'd0, ctrl_slot_o}, 32'd3);
    chk("err_wb_start", {31'd0, ctrl_start_o}, 32'd1);

    // Async reset after 10 words mid-load
    tick(1);
    v0 = vld_cnt;
    for (int i = 0; i < 10; i++) send_word(1'b0, 32'hC000_0000 + i, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, cfg_valid_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_error", {31'd0, error_o}, 32'd0);
    chk("mid_rst_slot", {28'd0, ctrl_slot_o}, 32'd0);
    chk("mid_rst_data", cfg_data_o, 32'd0);
    chk("mid_word_cnt", vld_cnt - v0, 32'd10);
    tick(2);
    warmboot_boot_i = 1'b0; ctrl_busy_i = 1'b0;
    rst_ni = 1'b1;
    tick(1);
    chk("fresh_start", {31'd0, ctrl_start_o}, 32'd1);
    chk("fresh_slot", {28'd0, ctrl_slot_o}, 32'd0);

    // Receiver mode from reset
    rst_ni = 1'b0; mode_i = 1'b1;
    tick(2);
    rst_ni = 1'b1;
    s0 = start_cnt;
    tick(3);
    v0 = vld_cnt;
    send_word(1'b1, 32'h1111_1111, 1'b1);
    send_word(1'b1, 32'h2222_2222, 1'b1);
    send_word(1'b1, 32'h3333_3333, 1'b1);
    send_word(1'b0, 32'h4444_4444, 1'b0);
    send_word(1'b0, 32'h5555_5555, 1'b0);
    warmboot_slot_i = 4'd7; warmboot_boot_i = 1'b1;
    tick(3);
    chk("rcv_no_start", start_cnt, s0);
    chk("rcv_wb_ignored", {31'd0, warmboot_reset_o}, 32'd0);
    chk("rcv_word_cnt", vld_cnt - v0, 32'd3);
    cfg_busy_i = 1'b1;
    tick(1);
    chk("cfg_busy_wbreset", {31'd0, warmboot_reset_o}, 32'd1);
    mode_i = 1'b0;
    tick(2);
    chk("rcv_hold_busy", start_cnt, s0);
    cfg_busy_i = 1'b0;
    tick(1);
    chk("rcv_exit_start", {31'd0, ctrl_start_o}, 32'd1);
    chk("rcv_exit_slot", {28'd0, ctrl_slot_o}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
